// File: rtl/multi_issuer.sv
// multi_issuer: in-order WIDTH-wide decode buffer and credit-gated issue stage with precise illegal-instruction trap
//   clk, rst (sync, active-low); iq_valid/iq_inst/iq_pc/iq_pc_next/iq_ready: IQ pop handshake
//   alu_free/br_free/lsq_free/rob_free: free-entry credits; flush: empties the buffer, returns to RUN
//   iss_*: per-slot issue bundle, slot k in bits [k*W +: W]; trap: illegal at head; stall_cnt: head-blocked cycles
//   iss_type: 0 alu, 1 br, 2 ls.  opr1_sel: 0 rs1, 1 pc, 2 zero.  opr2_sel: 0 rs2, 1 imm, 2 const 4.
//   opr3_sel: 0 none, 1 pc+imm, 2 rs2 (store data), 3 rs1+imm (jalr target).
//   br opc: funct3 for branches, 2 jal, 3 jalr.  ls opc: {store, funct3}.
module multi_issuer #(
  parameter int WIDTH    = 2,
  parameter int DQ_DEPTH = 4,
  parameter int CW       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iq_valid,
  input  logic [31:0]         iq_inst,
  input  logic [31:0]         iq_pc,
  input  logic [31:0]         iq_pc_next,
  output logic                iq_ready,
  input  logic [CW-1:0]       alu_free,
  input  logic [CW-1:0]       br_free,
  input  logic [CW-1:0]       lsq_free,
  input  logic [CW-1:0]       rob_free,
  input  logic                flush,
  output logic [WIDTH-1:0]    iss_valid,
  output logic [WIDTH*2-1:0]  iss_type,
  output logic [WIDTH*4-1:0]  iss_opc,
  output logic [WIDTH-1:0]    iss_isrd,
  output logic [WIDTH*5-1:0]  iss_rd,
  output logic [WIDTH*5-1:0]  iss_sr1,
  output logic [WIDTH*5-1:0]  iss_sr2,
  output logic [WIDTH*32-1:0] iss_imm,
  output logic [WIDTH*32-1:0] iss_pc,
  output logic [WIDTH*32-1:0] iss_pcnext,
  output logic [WIDTH*3-1:0]  iss_opr1_sel,
  output logic [WIDTH*3-1:0]  iss_opr2_sel,
  output logic [WIDTH*3-1:0]  iss_opr3_sel,
  output logic                trap,
  output logic [31:0]         stall_cnt
);
  localparam int AW = DQ_DEPTH > 1 ? $clog2(DQ_DEPTH) : 1;
  localparam logic [1:0] IT_ALU = 2'd0, IT_BR = 2'd1, IT_LS = 2'd2;
  typedef struct packed {
    logic        ill;
    logic [1:0]  typ;
    logic [3:0]  opc;
    logic        isrd;
    logic [4:0]  rd, sr1, sr2;
    logic [31:0] imm, pc, pcn;
    logic [2:0]  s1, s2, s3;
  } dq_t;
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_n;
  dq_t dq [DQ_DEPTH];
  dq_t dec;
  logic [AW-1:0] head, tail;
  logic [AW:0] count, npop;
  logic push, head_ill, stall_inc;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign f3    = iq_inst[14:12];
  assign imm_i = {{20{iq_inst[31]}}, iq_inst[31:20]};
  assign imm_s = {{20{iq_inst[31]}}, iq_inst[31:25], iq_inst[11:7]};
  assign imm_b = {{19{iq_inst[31]}}, iq_inst[31], iq_inst[7], iq_inst[30:25], iq_inst[11:8], 1'b0};
  assign imm_u = {iq_inst[31:12], 12'd0};
  assign imm_j = {{11{iq_inst[31]}}, iq_inst[31], iq_inst[19:12], iq_inst[20], iq_inst[30:21], 1'b0};
  always_comb begin
    dec = '0;
    dec.ill = 1'b1;
    dec.rd = iq_inst[11:7];
    dec.sr1 = iq_inst[19:15];
    dec.sr2 = iq_inst[24:20];
    dec.pc = iq_pc;
    dec.pcn = iq_pc_next;
    case (iq_inst[6:0])
      7'b0010011: begin dec.ill = 1'b0; dec.typ = IT_ALU; dec.opc = {f3 == 3'b101 && iq_inst[30], f3}; dec.isrd = 1'b1; dec.imm = imm_i; dec.s2 = 3'd1; end
      7'b0110011: begin dec.ill = 1'b0; dec.typ = IT_ALU; dec.opc = {iq_inst[30], f3}; dec.isrd = 1'b1; end
      7'b0110111: begin dec.ill = 1'b0; dec.typ = IT_ALU; dec.isrd = 1'b1; dec.imm = imm_u; dec.s1 = 3'd2; dec.s2 = 3'd1; end
      7'b0010111: begin dec.ill = 1'b0; dec.typ = IT_ALU; dec.isrd = 1'b1; dec.imm = imm_u; dec.s1 = 3'd1; dec.s2 = 3'd1; end
      7'b1100011: begin dec.ill = f3[2:1] == 2'b01; dec.typ = IT_BR; dec.opc = {1'b0, f3}; dec.imm = imm_b; dec.s3 = 3'd1; end
      7'b1101111: begin dec.ill = 1'b0; dec.typ = IT_BR; dec.opc = 4'd2; dec.isrd = 1'b1; dec.imm = imm_j; dec.s1 = 3'd1; dec.s2 = 3'd2; dec.s3 = 3'd1; end
      7'b1100111: begin dec.ill = f3 != 3'd0; dec.typ = IT_BR; dec.opc = 4'd3; dec.isrd = 1'b1; dec.imm = imm_i; dec.s1 = 3'd1; dec.s2 = 3'd2; dec.s3 = 3'd3; end
      7'b0000011: begin dec.ill = f3 == 3'b011 || f3[2:1] == 2'b11; dec.typ = IT_LS; dec.opc = {1'b0, f3}; dec.isrd = 1'b1; dec.imm = imm_i; dec.s2 = 3'd1; end
      7'b0100011: begin dec.ill = f3 > 3'b010; dec.typ = IT_LS; dec.opc = {1'b1, f3}; dec.imm = imm_s; dec.s2 = 3'd1; dec.s3 = 3'd2; end
      default: dec.ill = 1'b1;
    endcase
  end
  // Each slot sees the cumulative demand of itself and all older slots, so a
  // blocked slot also blocks every younger one and order stays strict.
  always_comb begin
    int na, nb, nl;
    logic ok;
    logic [AW-1:0] idx;
    dq_t e;
    na = 0;
    nb = 0;
    nl = 0;
    ok = state == RUN && !flush;
    idx = head;
    e = dq[head];
    npop = '0;
    iss_valid = '0;
    iss_type = '0;
    iss_opc = '0;
    iss_isrd = '0;
    iss_rd = '0;
    iss_sr1 = '0;
    iss_sr2 = '0;
    iss_imm = '0;
    iss_pc = '0;
    iss_pcnext = '0;
    iss_opr1_sel = '0;
    iss_opr2_sel = '0;
    iss_opr3_sel = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = head + AW'(k);
      e = dq[idx];
      na += int'(e.typ == IT_ALU);
      nb += int'(e.typ == IT_BR);
      nl += int'(e.typ == IT_LS);
      ok = ok && k < int'(count) && !e.ill && na <= int'(alu_free) && nb <= int'(br_free)
           && nl <= int'(lsq_free) && k + 1 <= int'(rob_free);
      iss_valid[k] = ok;
      npop += {{AW{1'b0}}, ok};
      iss_type[k*2 +: 2] = e.typ;
      iss_opc[k*4 +: 4] = e.opc;
      iss_isrd[k] = e.isrd;
      iss_rd[k*5 +: 5] = e.rd;
      iss_sr1[k*5 +: 5] = e.sr1;
      iss_sr2[k*5 +: 5] = e.sr2;
      iss_imm[k*32 +: 32] = e.imm;
      iss_pc[k*32 +: 32] = e.pc;
      iss_pcnext[k*32 +: 32] = e.pcn;
      iss_opr1_sel[k*3 +: 3] = e.s1;
      iss_opr2_sel[k*3 +: 3] = e.s2;
      iss_opr3_sel[k*3 +: 3] = e.s3;
    end
  end
  assign iq_ready  = state == RUN && !flush && int'(count) < DQ_DEPTH;
  assign push      = iq_valid && iq_ready;
  assign head_ill  = count != '0 && dq[head].ill;
  assign stall_inc = count != '0 && !dq[head].ill && state == RUN && !flush && !iss_valid[0];
  assign trap      = state == TRAP;
  always_comb state_n = flush ? RUN : (state == RUN && head_ill) ? TRAP : state;
  always_ff @(posedge clk)
    if (!rst) state <= RUN;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) dq[tail] <= dec;
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        head <= head + npop[AW-1:0];
        tail <= tail + AW'(push);
        count <= count + {{AW{1'b0}}, push} - npop;
      end
      stall_cnt <= stall_cnt + {31'd0, stall_inc};
    end
  end
endmodule

// File: tb/tb_multi_issuer.sv
// tb_multi_issuer: directed-vector self-checking bench for multi_issuer (WIDTH=2, DQ_DEPTH=4)
module tb_multi_issuer;
  localparam logic [31:0] ADDI = 32'h0010_0093, ADD = 32'h0020_81B3, LW = 32'h0000_A203;
  localparam logic [31:0] BEQ = 32'h0020_8463, SW = 32'h0020_A223, ILL = 32'h0000_007F;
  logic clk = 1'b0, rst, iq_valid, iq_ready, flush, trap;
  logic [31:0] iq_inst, iq_pc, iq_pc_next, stall_cnt;
  logic [3:0] alu_free, br_free, lsq_free, rob_free;
  logic [1:0] iss_valid, iss_isrd;
  logic [3:0] iss_type;
  logic [7:0] iss_opc;
  logic [9:0] iss_rd, iss_sr1, iss_sr2;
  logic [63:0] iss_imm, iss_pc, iss_pcnext;
  logic [5:0] iss_opr1_sel, iss_opr2_sel, iss_opr3_sel;
  int n_cmp = 0, n_err = 0;
  logic [31:0] s;
  always #5 clk = ~clk;
  multi_issuer #(.WIDTH(2), .DQ_DEPTH(4), .CW(4)) dut (
    .clk(clk), .rst(rst), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
    .iq_pc_next(iq_pc_next), .iq_ready(iq_ready), .alu_free(alu_free), .br_free(br_free),
    .lsq_free(lsq_free), .rob_free(rob_free), .flush(flush), .iss_valid(iss_valid),
    .iss_type(iss_type), .iss_opc(iss_opc), .iss_isrd(iss_isrd), .iss_rd(iss_rd),
    .iss_sr1(iss_sr1), .iss_sr2(iss_sr2), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_pcnext(iss_pcnext), .iss_opr1_sel(iss_opr1_sel), .iss_opr2_sel(iss_opr2_sel),
    .iss_opr3_sel(iss_opr3_sel), .trap(trap), .stall_cnt(stall_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic enq(input logic [31:0] inst, input logic [31:0] pc);
    iq_valid = 1'b1;
    iq_inst = inst;
    iq_pc = pc;
    iq_pc_next = pc + 32'd4;
  endtask
  initial begin
    rst = 1'b0; flush = 1'b0; iq_valid = 1'b0; iq_inst = '0; iq_pc = '0; iq_pc_next = '0;
    alu_free = 4'd8; br_free = 4'd8; lsq_free = 4'd8; rob_free = 4'd8;
    step; step;
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(iss_valid), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_ready", 32'(iq_ready), 32'd1);
    enq(ADDI, 32'h0);
    step;
    for (int i = 1; i < 4; i++) begin
      check("stream_valid", 32'(iss_valid), 32'd1);
      check("stream_pc", iss_pc[31:0], 32'(4 * (i - 1)));
      enq(ADDI, 32'(4 * i));
      step;
    end
    check("stream_valid", 32'(iss_valid), 32'd1);
    check("stream_pc", iss_pc[31:0], 32'hC);
    check("stream_imm", iss_imm[31:0], 32'd1);
    check("stream_isrd", 32'(iss_isrd[0]), 32'd1);
    check("stream_pcnext", iss_pcnext[31:0], 32'h10);
    iq_valid = 1'b0;
    step;
    check("stream_empty", 32'(iss_valid), 32'd0);
    check("stream_stall", stall_cnt, 32'd0);
    rob_free = 4'd0;
    enq(ADD, 32'h10); step;
    enq(LW, 32'h14); step;
    enq(BEQ, 32'h18); step;
    enq(SW, 32'h1C); step;
    iq_valid = 1'b0; rob_free = 4'd8; lsq_free = 4'd1;
    #1;
    check("mix_valid1", 32'(iss_valid), 32'd3);
    check("mix_type1", 32'(iss_type), 32'h8);
    check("mix_opc1", 32'(iss_opc), 32'h20);
    check("mix_rd1", 32'(iss_rd), {22'd0, 5'd4, 5'd3});
    s = stall_cnt;
    step;
    lsq_free = 4'd0;
    #1;
    check("mix_valid2", 32'(iss_valid), 32'd1);
    check("mix_type2", 32'(iss_type[1:0]), 32'd1);
    check("mix_isrd2", 32'(iss_isrd[0]), 32'd0);
    check("mix_imm2", iss_imm[31:0], 32'd8);
    check("mix_pc2", iss_pc[31:0], 32'h18);
    step;
    check("mix_stall_keep", stall_cnt, s);
    check("mix_sw_block", 32'(iss_valid), 32'd0);
    step;
    check("mix_stall_inc", stall_cnt, s + 32'd1);
    lsq_free = 4'd1;
    #1;
    check("mix_sw_valid", 32'(iss_valid), 32'd1);
    check("mix_sw_type", 32'(iss_type[1:0]), 32'd2);
    check("mix_sw_imm", iss_imm[31:0], 32'd4);
    check("mix_sw_opc", 32'(iss_opc[3:0]), 32'hA);
    check("mix_sw_sel3", 32'(iss_opr3_sel[2:0]), 32'd2);
    step;
    check("mix_empty", 32'(iss_valid), 32'd0);
    lsq_free = 4'd8; rob_free = 4'd0;
    for (int i = 0; i < 4; i++) begin
      enq(ADDI, 32'h100 + 32'(4 * i));
      step;
    end
    enq(ADDI, 32'h110); rob_free = 4'd8;
    #1;
    check("full_ready", 32'(iq_ready), 32'd0);
    check("full_valid", 32'(iss_valid), 32'd3);
    check("full_pc1", iss_pc[63:32], 32'h104);
    step;
    check("full_ready_after", 32'(iq_ready), 32'd1);
    iq_valid = 1'b0;
    #1;
    check("full_valid2", 32'(iss_valid), 32'd3);
    check("full_pc2_0", iss_pc[31:0], 32'h108);
    check("full_pc2_1", iss_pc[63:32], 32'h10C);
    step;
    check("full_empty", 32'(iss_valid), 32'd0);
    rob_free = 4'd0;
    enq(ADDI, 32'h200); step;
    enq(ADDI, 32'h204); step;
    iq_valid = 1'b0;
    #1;
    s = stall_cnt;
    check("rob_block", 32'(iss_valid), 32'd0);
    repeat (5) step;
    check("rob_stall5", stall_cnt, s + 32'd5);
    rob_free = 4'd1;
    #1;
    check("rob_one", 32'(iss_valid), 32'd1);
    check("rob_one_pc", iss_pc[31:0], 32'h200);
    step;
    check("rob_two", 32'(iss_valid), 32'd1);
    check("rob_two_pc", iss_pc[31:0], 32'h204);
    step;
    check("rob_empty", 32'(iss_valid), 32'd0);
    rob_free = 4'd8;
    enq(ADDI, 32'h300); step;
    check("trap_addi", 32'(iss_valid), 32'd1);
    enq(ILL, 32'h304); step;
    check("trap_head_block", 32'(iss_valid), 32'd0);
    check("trap_not_yet", 32'(trap), 32'd0);
    s = stall_cnt;
    enq(ADDI, 32'h308); step;
    check("trap_set", 32'(trap), 32'd1);
    check("trap_ready", 32'(iq_ready), 32'd0);
    check("trap_valid", 32'(iss_valid), 32'd0);
    check("trap_stall", stall_cnt, s);
    step;
    check("trap_hold", 32'(trap), 32'd1);
    check("trap_stall_hold", stall_cnt, s);
    iq_valid = 1'b0; flush = 1'b1;
    #1;
    check("trap_flush_ready", 32'(iq_ready), 32'd0);
    step;
    flush = 1'b0;
    #1;
    check("trap_cleared", 32'(trap), 32'd0);
    check("trap_dq_empty", 32'(iss_valid), 32'd0);
    check("trap_stall_kept", stall_cnt, s);
    enq(ADDI, 32'h310); step;
    check("trap_resume", 32'(iss_valid), 32'd1);
    check("trap_resume_pc", iss_pc[31:0], 32'h310);
    iq_valid = 1'b0;
    step;
    rob_free = 4'd0;
    enq(ADDI, 32'h400); step;
    enq(ADDI, 32'h404); step;
    rob_free = 4'd8; flush = 1'b1;
    enq(ADDI, 32'h408);
    #1;
    check("flush_valid", 32'(iss_valid), 32'd0);
    check("flush_ready", 32'(iq_ready), 32'd0);
    step;
    flush = 1'b0; iq_valid = 1'b0;
    #1;
    check("flush_empty", 32'(iss_valid), 32'd0);
    check("flush_ready_after", 32'(iq_ready), 32'd1);
    rob_free = 4'd0;
    enq(ADDI, 32'h500); step;
    enq(ADDI, 32'h504); rst = 1'b0;
    step;
    rst = 1'b1; iq_valid = 1'b0; rob_free = 4'd8;
    #1;
    check("rst2_valid", 32'(iss_valid), 32'd0);
    check("rst2_stall", stall_cnt, 32'd0);
    check("rst2_trap", 32'(trap), 32'd0);
    check("rst2_ready", 32'(iq_ready), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
